// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer producing the 9-bit micro-address {alt, op, step}
// Optional memory wait watchdog enabled by defining MSEQ_TIMEOUT_EN.
module micro_sequencer #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  opcode,
   input  logic        z,
   input  logic        hit,
   output logic [8:0]  addr_ins,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] retired,
   output logic        mem_timeout
);

   localparam logic [4:0] OP_LOAD  = 5'b11100;
   localparam logic [4:0] OP_STORE = 5'b11101;
   localparam logic [4:0] OP_GOTOZ = 5'b10110;
   localparam logic [4:0] OP_HALT  = 5'b11111;

   typedef enum logic [4:0] {
      S_FETCH1, S_FETCH_WAIT, S_FETCH_FIN1, S_FETCH_FIN2,
      S_STEP,
      S_LOAD0, S_LOAD_WAIT, S_LOAD_HIT, S_LOAD2, S_LOAD3,
      S_STORE0, S_STORE1, S_STORE_WAIT, S_STORE3,
      S_GOTOZ, S_GOTOZ_TAKEN, S_GOTOZ_NOT,
      S_HALT, S_INCPC
   } state_t;

   state_t     state, state_nx;
   logic [4:0] op_q, op_nx;
   logic [2:0] step_q, step_nx;
   logic       illegal_raw;
   logic       retire;
   logic       timeout_hit;

   function automatic logic is_straight(input logic [4:0] o);
      case (o)
         5'b11010, 5'b01010, 5'b11001, 5'b01011, 5'b00011,
         5'b00101, 5'b00100, 5'b10100, 5'b10101,
         5'b11011, 5'b10001, 5'b10010, 5'b01101: is_straight = 1'b1;
         default:                                is_straight = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] last_step(input logic [4:0] o);
      case (o)
         5'b11011:           last_step = 3'b010;
         5'b10001, 5'b10010: last_step = 3'b011;
         5'b01101:           last_step = 3'b000;
         default:            last_step = 3'b001;
      endcase
   endfunction

   function automatic logic [8:0] addr_of(input state_t s, input logic [4:0] o, input logic [2:0] st);
      case (s)
         S_FETCH1:      addr_of = 9'b000000000;
         S_FETCH_WAIT:  addr_of = 9'b000000010;
         S_FETCH_FIN1:  addr_of = 9'b100000010;
         S_FETCH_FIN2:  addr_of = 9'b100000011;
         S_STEP:        addr_of = {1'b0, o, st};
         S_LOAD0:       addr_of = {1'b0, OP_LOAD, 3'b000};
         S_LOAD_WAIT:   addr_of = {1'b0, OP_LOAD, 3'b110};
         S_LOAD_HIT:    addr_of = {1'b1, OP_LOAD, 3'b110};
         S_LOAD2:       addr_of = {1'b0, OP_LOAD, 3'b010};
         S_LOAD3:       addr_of = {1'b0, OP_LOAD, 3'b011};
         S_STORE0:      addr_of = {1'b0, OP_STORE, 3'b000};
         S_STORE1:      addr_of = {1'b0, OP_STORE, 3'b001};
         S_STORE_WAIT:  addr_of = {1'b0, OP_STORE, 3'b010};
         S_STORE3:      addr_of = {1'b0, OP_STORE, 3'b011};
         S_GOTOZ:       addr_of = {1'b0, OP_GOTOZ, 3'b000};
         S_GOTOZ_TAKEN: addr_of = {1'b0, OP_GOTOZ, 3'b001};
         S_GOTOZ_NOT:   addr_of = {1'b1, OP_GOTOZ, 3'b001};
         S_HALT:        addr_of = {1'b0, OP_HALT, 3'b111};
         default:       addr_of = 9'b000000001;
      endcase
   endfunction

`ifdef MSEQ_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] wd_q;
   logic           wait_state;

   assign wait_state  = (state == S_FETCH_WAIT) || (state == S_LOAD_WAIT) || (state == S_STORE_WAIT);
   assign timeout_hit = wait_state && !hit && (wd_q == WDW'(TIMEOUT - 1));

   // Counts consecutive hit-less wait cycles; any exit from a wait state clears it.
   always_ff @(posedge clk) begin
      if (reset)
         wd_q <= '0;
      else if (en) begin
         if (wait_state && !hit && !timeout_hit)
            wd_q <= wd_q + 1'b1;
         else
            wd_q <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nx    = state;
      op_nx       = op_q;
      step_nx     = step_q;
      illegal_raw = 1'b0;
      retire      = 1'b0;
      case (state)
         S_FETCH1:      state_nx = S_FETCH_WAIT;
         S_FETCH_WAIT:  if (hit) state_nx = S_FETCH_FIN1;
         S_FETCH_FIN1:  state_nx = S_FETCH_FIN2;
         S_FETCH_FIN2: begin
            op_nx   = opcode;
            step_nx = 3'b000;
            if (is_straight(opcode))
               state_nx = S_STEP;
            else begin
               case (opcode)
                  OP_LOAD:  state_nx = S_LOAD0;
                  OP_STORE: state_nx = S_STORE0;
                  OP_GOTOZ: state_nx = S_GOTOZ;
                  OP_HALT:  state_nx = S_HALT;
                  default: begin
                     state_nx    = S_INCPC;
                     illegal_raw = 1'b1;
                  end
               endcase
            end
         end
         S_STEP: begin
            if (step_q == last_step(op_q))
               state_nx = S_INCPC;
            else
               step_nx = step_q + 3'd1;
         end
         S_LOAD0:       state_nx = S_LOAD_WAIT;
         S_LOAD_WAIT:   if (hit) state_nx = S_LOAD_HIT;
         S_LOAD_HIT:    state_nx = S_LOAD2;
         S_LOAD2:       state_nx = S_LOAD3;
         S_LOAD3:       state_nx = S_INCPC;
         S_STORE0:      state_nx = S_STORE1;
         S_STORE1:      state_nx = S_STORE_WAIT;
         S_STORE_WAIT:  if (hit) state_nx = S_STORE3;
         S_STORE3:      state_nx = S_INCPC;
         S_GOTOZ:       state_nx = z ? S_GOTOZ_TAKEN : S_GOTOZ_NOT;
         // A taken branch has already loaded the PC, so it retires without INCPC.
         S_GOTOZ_TAKEN: begin
            state_nx = S_FETCH1;
            retire   = 1'b1;
         end
         S_GOTOZ_NOT:   state_nx = S_INCPC;
         S_HALT:        state_nx = S_HALT;
         S_INCPC: begin
            state_nx = S_FETCH1;
            retire   = 1'b1;
         end
         default:       state_nx = S_FETCH1;
      endcase
      if (timeout_hit)
         state_nx = S_FETCH1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH1;
         op_q     <= 5'b00000;
         step_q   <= 3'b000;
         addr_ins <= 9'b000000000;
         retired  <= 16'h0000;
      end else if (en) begin
         state    <= state_nx;
         op_q     <= op_nx;
         step_q   <= step_nx;
         addr_ins <= addr_of(state_nx, op_nx, step_nx);
         if (retire)
            retired <= retired + 16'd1;
      end
   end

   assign halted      = (state == S_HALT);
   assign illegal     = en && !reset && illegal_raw;
   assign mem_timeout = en && !reset && timeout_hit;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - self-checking bench for micro_sequencer
module tb_micro_sequencer;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b1;
   logic [4:0]  opcode = 5'b00000;
   logic        z = 1'b0;
   logic        hit = 1'b1;
   logic [8:0]  addr_ins;
   logic        halted;
   logic        illegal;
   logic [15:0] retired;
   logic        mem_timeout;

   int n_cmp = 0;
   int n_err = 0;
   int ill_cnt = 0;
   int to_cnt = 0;

   micro_sequencer #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .en(en), .opcode(opcode), .z(z), .hit(hit),
      .addr_ins(addr_ins), .halted(halted), .illegal(illegal),
      .retired(retired), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   // Reference model: micro-address walked directly by its {alt, op, step} fields.
   logic [8:0]  m_addr = 9'b000000000;
   logic [15:0] m_ret = 16'h0000;
   int          m_wd = 0;

   function automatic int last_step(input logic [4:0] o);
      case (o)
         5'b11010, 5'b01010, 5'b11001, 5'b01011, 5'b00011,
         5'b00101, 5'b00100, 5'b10100, 5'b10101: return 1;
         5'b11011:                               return 2;
         5'b10001, 5'b10010:                     return 3;
         5'b01101:                               return 0;
         default:                                return -1;
      endcase
   endfunction

   function automatic bit undefined_op(input logic [4:0] o);
      return last_step(o) < 0 && !(o inside {5'b11100, 5'b11101, 5'b10110, 5'b11111});
   endfunction

   function automatic bit is_wait(input logic [8:0] a);
      return a == 9'b000000010 || a == 9'b011100110 || a == 9'b011101010;
   endfunction

   function automatic logic [8:0] next_addr(input logic [8:0] a, input logic [4:0] o,
                                            input logic zz, input logic h);
      logic [4:0] f_op;
      logic [2:0] f_st;
      f_op = a[7:3];
      f_st = a[2:0];
      if (is_wait(a) && !h) return a;
      case (a)
         9'b000000000: return 9'b000000010;
         9'b000000010: return 9'b100000010;
         9'b100000010: return 9'b100000011;
         9'b100000011: begin
            if (o == 5'b11111) return 9'b011111111;
            if (undefined_op(o)) return 9'b000000001;
            return {1'b0, o, 3'b000};
         end
         9'b000000001: return 9'b000000000;
         9'b011100000: return 9'b011100110;
         9'b011100110: return 9'b111100110;
         9'b111100110: return 9'b011100010;
         9'b011100010: return 9'b011100011;
         9'b011100011: return 9'b000000001;
         9'b011101011: return 9'b000000001;
         9'b010110000: return zz ? 9'b010110001 : 9'b110110001;
         9'b010110001: return 9'b000000000;
         9'b110110001: return 9'b000000001;
         9'b011111111: return a;
         default: ;
      endcase
      if (a[8:3] == 6'b011101) return a + 9'd1;
      if (int'(f_st) == last_step(f_op)) return 9'b000000001;
      return a + 9'd1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: pulses checked before the edge, registered state after it.
   task automatic cyc();
      logic       exp_ill, exp_to;
      logic [8:0] nx;
      @(negedge clk);
      exp_ill = en && !reset && m_addr == 9'b100000011 && undefined_op(opcode);
`ifdef MSEQ_TIMEOUT_EN
      exp_to = en && !reset && is_wait(m_addr) && !hit && m_wd == TO - 1;
`else
      exp_to = 1'b0;
`endif
      chk("illegal", illegal, exp_ill);
      chk("mem_timeout", mem_timeout, exp_to);
      if (illegal === 1'b1) ill_cnt++;
      if (mem_timeout === 1'b1) to_cnt++;
      @(posedge clk);
      if (reset) begin
         m_addr = 9'b000000000; m_ret = 16'h0000; m_wd = 0;
      end else if (en) begin
         if (exp_to) begin
            m_addr = 9'b000000000; m_wd = 0;
         end else begin
            nx = next_addr(m_addr, opcode, z, hit);
            if (nx == 9'b000000000 && (m_addr == 9'b000000001 || m_addr == 9'b010110001))
               m_ret = m_ret + 16'd1;
            m_wd = (is_wait(m_addr) && !hit) ? m_wd + 1 : 0;
            m_addr = nx;
         end
      end
      #1;
      chk("addr_ins", addr_ins, m_addr);
      chk("halted", halted, m_addr == 9'b011111111);
      chk("retired", retired, m_ret);
   endtask

   task automatic do_reset();
      reset = 1'b1; en = 1'b1; hit = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic fetch(input logic [4:0] op);
      en = 1'b1; hit = 1'b1; opcode = op;
      repeat (4) cyc();
   endtask

   typedef struct {
      logic        rst;
      logic [4:0]  op;
      logic [8:0]  ea;
      logic [15:0] er;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int ill0, to0;
      logic [15:0] ret0;

      tbl[0] = '{1'b1, 5'b01010, 9'b000000000, 16'd0};
      tbl[1] = '{1'b0, 5'b01010, 9'b000000010, 16'd0};
      tbl[2] = '{1'b0, 5'b01010, 9'b100000010, 16'd0};
      tbl[3] = '{1'b0, 5'b01010, 9'b100000011, 16'd0};
      tbl[4] = '{1'b0, 5'b01010, 9'b001010000, 16'd0};
      tbl[5] = '{1'b0, 5'b01010, 9'b001010001, 16'd0};
      tbl[6] = '{1'b0, 5'b01010, 9'b000000001, 16'd0};
      tbl[7] = '{1'b0, 5'b01010, 9'b000000000, 16'd1};

      for (int i = 0; i < 8; i++) begin
         reset = tbl[i].rst; en = 1'b1; hit = 1'b1; opcode = tbl[i].op;
         cyc();
         chk("tbl_addr", addr_ins, tbl[i].ea);
         chk("tbl_retired", retired, tbl[i].er);
      end
      reset = 1'b0;

      // LOAD held five cycles in its wait state.
      do_reset();
      fetch(5'b11100);
      hit = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("load_wait_hold", addr_ins, 9'b011100110);
      end
      hit = 1'b1;
      cyc(); chk("load_hit", addr_ins, 9'b111100110);
      cyc(); chk("load_s2", addr_ins, 9'b011100010);
      cyc(); chk("load_s3", addr_ins, 9'b011100011);
      cyc(); chk("load_incpc", addr_ins, 9'b000000001);

      // GOTOZ taken and not taken.
      do_reset();
      fetch(5'b10110);
      chk("gotoz_entry", addr_ins, 9'b010110000);
      z = 1'b1;
      cyc(); chk("gotoz_t1", addr_ins, 9'b010110001);
      cyc(); chk("gotoz_t2", addr_ins, 9'b000000000);
      chk("gotoz_t_ret", retired, 16'd1);
      fetch(5'b10110);
      z = 1'b0;
      cyc(); chk("gotoz_n1", addr_ins, 9'b110110001);
      cyc(); chk("gotoz_n2", addr_ins, 9'b000000001);

      // Undefined opcode runs as a NOP with a single illegal pulse.
      do_reset();
      ill0 = ill_cnt;
      fetch(5'b00111);
      chk("illegal_once", ill_cnt - ill0, 1);
      chk("illegal_next", addr_ins, 9'b000000001);

      // HALT parks until reset.
      fetch(5'b00000);
      cyc(); cyc();
      fetch(5'b11111);
      opcode = 5'b01010;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("halt_hold", {halted, addr_ins}, {1'b1, 9'b011111111});
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("halt_reset", {halted, addr_ins}, {1'b0, 9'b000000000});

      // Enable low mid-ADDL.
      fetch(5'b10001);
      cyc(); cyc();
      chk("addl_s2", addr_ins, 9'b010001010);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("en_freeze", addr_ins, 9'b010001010);
      end
      en = 1'b1;
      cyc(); chk("en_resume", addr_ins, 9'b010001011);
      cyc(); cyc();
      chk("addl_ret", retired, 16'd1);

      // Reset mid-wait.
      hit = 1'b0;
      cyc(); cyc();
      chk("fw_wait", addr_ins, 9'b000000010);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("fw_reset_addr", addr_ins, 9'b000000000);
      chk("fw_reset_ret", retired, 16'd0);

`ifdef MSEQ_TIMEOUT_EN
      fetch(5'b01101);
      cyc(); cyc();
      ret0 = retired;
      to0 = to_cnt;
      hit = 1'b0;
      cyc();
      for (int i = 0; i < TO - 1; i++) cyc();
      chk("to_none_early", to_cnt - to0, 0);
      cyc();
      chk("to_pulse", to_cnt - to0, 1);
      chk("to_addr", addr_ins, 9'b000000000);
      chk("to_ret", retired, ret0);
`else
      ret0 = retired;
      to0 = to_cnt;
      hit = 1'b0;
      for (int i = 0; i < 40; i++) cyc();
      chk("unbounded_wait", addr_ins, 9'b000000010);
      chk("no_timeout", to_cnt - to0, 0);
      chk("wait_ret", retired, ret0);
`endif

      // Randomized run against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         en = ($urandom_range(0, 7) != 0);
         hit = ($urandom_range(0, 2) == 0);
         z = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 99) < 3)
            opcode = 5'b11111;
         else begin
            opcode = 5'($urandom_range(0, 31));
            if (opcode == 5'b11111) opcode = 5'b01010;
         end
         cyc();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
